debouncer_botones: RTL and testbench

- Upstream conditioning stage for the board pushbuttons, inserted between the raw button pins and the `i_botones` input of `configurador`.
- Synchronises each asynchronous button to `i_clock` and filters contact bounce.
- Emits one single-cycle pulse per confirmed press, so `configurador` latches each operand or opcode exactly once per physical press.
- All buttons are filtered independently and in parallel.

---
 rtl/debouncer_botones.sv | 132 +++++++++++++
 tb/tb_debouncer_botones.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_botones.sv
// Per-button two-flop synchroniser plus a debounce FSM. It emits one registered
// pulse per confirmed press and a debounced level for each button.
module debouncer_botones #(
  parameter int CANT_BOTONES   = 4,
  parameter int CICLOS_ESTABLE = 1000000,
  parameter int ANCHO_CONTADOR = 20
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [CANT_BOTONES-1:0] i_botones,
  output logic [CANT_BOTONES-1:0] o_botones_pulso,
  output logic [CANT_BOTONES-1:0] o_botones_estado,
  output logic                    o_algun_pulso
);

  typedef enum logic [1:0] {
    REPOSO      = 2'd0,
    ESPERA_ALTO = 2'd1,
    PULSADO     = 2'd2,
    ESPERA_BAJO = 2'd3
  } estado_t;

  // Last count value of a stable run; the counter never goes past it.
  localparam logic [ANCHO_CONTADOR-1:0] CNT_MAX = ANCHO_CONTADOR'(CICLOS_ESTABLE - 1);

  logic [CANT_BOTONES-1:0] sync1;
  logic [CANT_BOTONES-1:0] sync2;
  logic [CANT_BOTONES-1:0] s;
  logic [CANT_BOTONES-1:0] pulso_next;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_botones;
      sync2 <= sync1;
    end
  end

  assign s = sync2;

  for (genvar gi = 0; gi < CANT_BOTONES; gi++) begin : g_boton
    estado_t                   st_q;
    estado_t                   st_n;
    logic [ANCHO_CONTADOR-1:0] cnt_q;
    logic [ANCHO_CONTADOR-1:0] cnt_n;
    logic                      nivel_q;
    logic                      nivel_n;
    logic                      pulso_q;
    logic                      pulso_n;

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        st_q    <= REPOSO;
        cnt_q   <= '0;
        nivel_q <= 1'b0;
        pulso_q <= 1'b0;
      end else begin
        st_q    <= st_n;
        cnt_q   <= cnt_n;
        nivel_q <= nivel_n;
        pulso_q <= pulso_n;
      end
    end

    always_comb begin
      st_n    = st_q;
      cnt_n   = cnt_q;
      nivel_n = nivel_q;
      pulso_n = 1'b0;
      case (st_q)
        REPOSO: begin
          if (s[gi]) begin
            st_n  = ESPERA_ALTO;
            cnt_n = '0;
          end
        end
        ESPERA_ALTO: begin
          if (!s[gi]) begin
            st_n  = REPOSO;
            cnt_n = '0;
          end else if (cnt_q == CNT_MAX) begin
            st_n    = PULSADO;
            cnt_n   = '0;
            nivel_n = 1'b1;
            pulso_n = 1'b1;
          end else begin
            cnt_n = cnt_q + ANCHO_CONTADOR'(1);
          end
        end
        PULSADO: begin
          if (!s[gi]) begin
            st_n  = ESPERA_BAJO;
            cnt_n = '0;
          end
        end
        ESPERA_BAJO: begin
          // A bounce back to 1 returns to PULSADO silently: still the same press.
          if (s[gi]) begin
            st_n  = PULSADO;
            cnt_n = '0;
          end else if (cnt_q == CNT_MAX) begin
            st_n    = REPOSO;
            cnt_n   = '0;
            nivel_n = 1'b0;
          end else begin
            cnt_n = cnt_q + ANCHO_CONTADOR'(1);
          end
        end
        default: begin
          st_n  = REPOSO;
          cnt_n = '0;
        end
      endcase
    end

    assign pulso_next[gi]       = pulso_n;
    assign o_botones_pulso[gi]  = pulso_q;
    assign o_botones_estado[gi] = nivel_q;
  end

  // Built from the next-state pulses so it lines up with o_botones_pulso.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_algun_pulso <= 1'b0;
    end else begin
      o_algun_pulso <= |pulso_next;
    end
  end

endmodule

// File: tb/tb_debouncer_botones.sv
// Bench for debouncer_botones: expected pulses (value and edge number) are queued
// when stimulus is applied and consumed by a monitor when the DUT pulses.
module tb_debouncer_botones;

  localparam int N = 4;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         i_reset = 1'b1;
  logic [N-1:0] i_botones = '0;
  logic [N-1:0] o_botones_pulso;
  logic [N-1:0] o_botones_estado;
  logic         o_algun_pulso;

  logic [N-1:0] botones2 = '0;
  logic [N-1:0] pulso2;
  logic [N-1:0] estado2;
  logic         algun2;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  logic [N-1:0] exp_q[$];
  int           exp_cyc_q[$];

  debouncer_botones #(.CANT_BOTONES(N), .CICLOS_ESTABLE(C), .ANCHO_CONTADOR(3)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_botones(i_botones),
    .o_botones_pulso(o_botones_pulso), .o_botones_estado(o_botones_estado),
    .o_algun_pulso(o_algun_pulso)
  );

  debouncer_botones #(.CANT_BOTONES(N), .CICLOS_ESTABLE(2), .ANCHO_CONTADOR(3)) dut2 (
    .i_clock(clk), .i_reset(i_reset), .i_botones(botones2),
    .o_botones_pulso(pulso2), .o_botones_estado(estado2),
    .o_algun_pulso(algun2)
  );

  // Clock and edge counter: cyc is the number of the most recent rising edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the main DUT.
  always @(negedge clk) begin
    if (mon_en) begin
      tests_run++;
      if (o_algun_pulso !== (|o_botones_pulso)) begin
        tests_failed++;
        $display("FAIL algun_pulso @%0d: got %b, required %b", cyc, o_algun_pulso, |o_botones_pulso);
      end
      if (o_botones_pulso !== '0) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_pulso @%0d: got %b, required none", cyc, o_botones_pulso);
        end else begin
          logic [N-1:0] e;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if (o_botones_pulso !== e || cyc != ec) begin
            tests_failed++;
            $display("FAIL pulso: got %b at edge %0d, required %b at edge %0d", o_botones_pulso, cyc, e, ec);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic expect_pulse(input logic [N-1:0] v, input int edge_n);
    exp_q.push_back(v);
    exp_cyc_q.push_back(edge_n);
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s missing_pulso: got %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic check_estado(input string name, input logic [N-1:0] v);
    tests_run++;
    if (o_botones_estado !== v) begin
      tests_failed++;
      $display("FAIL %s estado @%0d: got %b, required %b", name, cyc, o_botones_estado, v);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_botones = '0;
    tick(3);
    tests_run++;
    if (o_botones_pulso !== '0 || o_botones_estado !== '0 || o_algun_pulso !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got p=%b e=%b a=%b, required all 0",
               o_botones_pulso, o_botones_estado, o_algun_pulso);
    end
    mon_en = 1'b1;
    i_reset = 1'b0;
    tick(2);
  endtask

  task automatic test_single_press();
    int e0;
    i_botones = 4'b0001;
    e0 = cyc + 1;
    expect_pulse(4'b0001, e0 + C + 2);
    wait_edge(e0 + C + 1);
    check_estado("press_before", 4'b0000);
    tick(1);
    check_estado("press_at", 4'b0001);
    tick(50);
    check_estado("press_held", 4'b0001);
    check_drained("press");
    i_botones = '0;
    tick(C + 6);
    check_estado("press_released", 4'b0000);
  endtask

  task automatic test_glitch();
    logic [6:0] patt;
    patt = 7'b1110101;
    for (int i = 0; i < 7; i++) begin
      i_botones = {2'b00, patt[i], 1'b0};
      tick(1);
      check_estado("glitch_run", 4'b0000);
    end
    i_botones = '0;
    for (int i = 0; i < C + 4; i++) begin
      tick(1);
      check_estado("glitch_after", 4'b0000);
    end
  endtask

  task automatic test_release_bounce();
    int e0;
    int r0;
    i_botones = 4'b0100;
    e0 = cyc + 1;
    expect_pulse(4'b0100, e0 + C + 2);
    tick(20);
    check_estado("bounce_held", 4'b0100);
    i_botones = 4'b0000;
    tick(1);
    i_botones = 4'b0100;
    tick(2);
    i_botones = 4'b0000;
    r0 = cyc + 1;
    while (cyc < r0 + C + 1) begin
      tick(1);
      check_estado("bounce_hold_level", 4'b0100);
    end
    tick(1);
    check_estado("bounce_fall", 4'b0000);
    check_drained("bounce");
  endtask

  task automatic test_back_to_back();
    int e0;
    i_botones = 4'b1010;
    e0 = cyc + 1;
    expect_pulse(4'b1010, e0 + C + 2);
    wait_edge(e0 + C + 2);
    check_estado("simul_at", 4'b1010);
    tick(10);
    check_estado("simul_held", 4'b1010);
    check_drained("simul");
    i_botones = '0;
    tick(C + 6);
    check_estado("simul_released", 4'b0000);
  endtask

  task automatic test_reset_mid();
    int e0;
    i_botones = 4'b1000;
    e0 = cyc + 1;
    wait_edge(e0 + 3);
    i_reset = 1'b1;
    tick(1);
    tests_run++;
    if (o_botones_pulso !== '0 || o_botones_estado !== '0 || o_algun_pulso !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got p=%b e=%b a=%b, required all 0",
               o_botones_pulso, o_botones_estado, o_algun_pulso);
    end
    i_reset = 1'b0;
    expect_pulse(4'b1000, cyc + 1 + C + 2);
    tick(25);
    check_estado("reset_mid_held", 4'b1000);
    check_drained("reset_mid");
    i_botones = '0;
    tick(C + 6);
    check_estado("reset_mid_released", 4'b0000);
  endtask

  task automatic test_min_param();
    int e0;
    botones2 = 4'b0001;
    e0 = cyc + 1;
    wait_edge(e0 + 3);
    tests_run++;
    if (pulso2 !== 4'b0000) begin
      tests_failed++;
      $display("FAIL min_param_early: got %b, required 0000", pulso2);
    end
    tick(1);
    tests_run++;
    if (pulso2 !== 4'b0001 || algun2 !== 1'b1 || estado2 !== 4'b0001) begin
      tests_failed++;
      $display("FAIL min_param_pulse: got p=%b a=%b e=%b, required 0001 1 0001", pulso2, algun2, estado2);
    end
    tick(1);
    tests_run++;
    if (pulso2 !== 4'b0000 || algun2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL min_param_width: got p=%b a=%b, required 0000 0", pulso2, algun2);
    end
    botones2 = '0;
    tick(8);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_release_bounce();
    test_back_to_back();
    test_reset_mid();
    test_min_param();
    check_drained("final");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
